demux_1x8_tdm: RTL and testbench

Time-division 1-to-8 demultiplexer: the receive-side counterpart of the 8:1 mux. Samples one serial word per valid cycle, steers it into slot a..h under an internal 3-bit slot counter, and presents a complete, stable 8-slot frame on registered outputs. Sits after the mux/serial link and feeds parallel consumers that need all eight channels at once.

---
 rtl/demux_1x8_tdm_pkg.sv | 26 ++
 rtl/demux_1x8_tdm_if.sv | 38 +++
 rtl/demux_1x8_tdm_slot_ctr.sv | 49 ++++
 rtl/demux_1x8_tdm.sv | 88 ++++++++
 tb/tb_demux_1x8_tdm.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/demux_1x8_tdm_pkg.sv
// Shared slot constants and helpers for the 1:8 TDM demultiplexer.
// Slot indices match the 8:1 mux ordering (slot 0 = a ... slot 7 = h).
package demux_1x8_tdm_pkg;

  localparam int SLOT_W    = 3;
  localparam int NUM_SLOTS = 8;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = 3'd7;

  localparam slot_t SLOT_A = 3'd0;
  localparam slot_t SLOT_B = 3'd1;
  localparam slot_t SLOT_C = 3'd2;
  localparam slot_t SLOT_D = 3'd3;
  localparam slot_t SLOT_E = 3'd4;
  localparam slot_t SLOT_F = 3'd5;
  localparam slot_t SLOT_G = 3'd6;
  localparam slot_t SLOT_H = 3'd7;

  // Natural 3-bit overflow gives the mod-8 wrap from slot 7 back to slot 0.
  function automatic slot_t slot_inc(input slot_t s);
    return s + slot_t'(1);
  endfunction

endpackage

// File: rtl/demux_1x8_tdm_if.sv
// Serial-in / parallel-frame-out bundle of the 1:8 TDM demultiplexer.
// master = upstream link plus frame consumer, slave = the demultiplexer.
interface demux_1x8_tdm_if #(
  parameter int DATA_W = 1
);

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              sync;

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] e;
  logic [DATA_W-1:0] f;
  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] h;

  logic              sel0;
  logic              sel1;
  logic              sel2;
  logic              frame_done;
  logic              sync_err;

  modport master (
    output din, din_valid, sync,
    input  a, b, c, d, e, f, g, h,
    input  sel0, sel1, sel2, frame_done, sync_err
  );

  modport slave (
    input  din, din_valid, sync,
    output a, b, c, d, e, f, g, h,
    output sel0, sel1, sel2, frame_done, sync_err
  );

endinterface

// File: rtl/demux_1x8_tdm_slot_ctr.sv
// Slot counter for the TDM demux: tracks the next expected slot, applies sync,
// flags the frame-closing word and registers a pulse when sync cuts a partial frame.
module demux_slot_ctr
  import demux_1x8_tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  valid_i,
  input  logic  sync_i,
  output slot_t cnt_o,
  output slot_t eff_slot_o,
  output logic  last_o,
  output logic  sync_err_o
);

  slot_t cnt_q;
  slot_t cnt_d;
  slot_t eff_slot;
  logic  sync_err_q;
  logic  sync_err_d;

  always_comb begin
    eff_slot   = sync_i ? SLOT_A : cnt_q;
    cnt_d      = cnt_q;
    sync_err_d = sync_i && (cnt_q != SLOT_A);
    if (valid_i) begin
      cnt_d = slot_inc(eff_slot);
    end else if (sync_i) begin
      cnt_d = SLOT_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= SLOT_A;
      sync_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

  // A sync forces slot 0, so a synced word can never close a frame.
  assign last_o     = valid_i && (eff_slot == LAST_SLOT);
  assign eff_slot_o = eff_slot;
  assign cnt_o      = cnt_q;
  assign sync_err_o = sync_err_q;

endmodule

// File: rtl/demux_1x8_tdm.sv
// Time-division 1:8 demultiplexer: words collect in shadow slots 0..6 and the
// whole frame is published to a..h, with slot 7 taken straight from din, in one edge.
module demux_1x8_tdm
  import demux_1x8_tdm_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  demux_1x8_tdm_if.slave bus
);

  localparam int SHADOW_N = NUM_SLOTS - 1;

  typedef logic [DATA_W-1:0] word_t;

  slot_t cnt;
  slot_t eff_slot;
  logic  last;
  logic  sync_err;

  word_t shadow_q [SHADOW_N];
  word_t shadow_d [SHADOW_N];
  word_t frame_q  [NUM_SLOTS];
  word_t frame_d  [NUM_SLOTS];
  logic  frame_done_q;
  logic  frame_done_d;

  demux_slot_ctr u_slot_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (bus.din_valid),
    .sync_i     (bus.sync),
    .cnt_o      (cnt),
    .eff_slot_o (eff_slot),
    .last_o     (last),
    .sync_err_o (sync_err)
  );

  always_comb begin
    shadow_d     = shadow_q;
    frame_d      = frame_q;
    frame_done_d = last;
    for (int i = 0; i < SHADOW_N; i++) begin
      if (bus.din_valid && (eff_slot == slot_t'(i))) begin
        shadow_d[i] = bus.din;
      end
    end
    if (last) begin
      for (int i = 0; i < SHADOW_N; i++) begin
        frame_d[i] = shadow_q[i];
      end
      frame_d[LAST_SLOT] = bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SHADOW_N; i++) begin
        shadow_q[i] <= '0;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        frame_q[i] <= '0;
      end
      frame_done_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.a = frame_q[SLOT_A];
  assign bus.b = frame_q[SLOT_B];
  assign bus.c = frame_q[SLOT_C];
  assign bus.d = frame_q[SLOT_D];
  assign bus.e = frame_q[SLOT_E];
  assign bus.f = frame_q[SLOT_F];
  assign bus.g = frame_q[SLOT_G];
  assign bus.h = frame_q[SLOT_H];

  assign bus.sel0       = cnt[0];
  assign bus.sel1       = cnt[1];
  assign bus.sel2       = cnt[2];
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err;

endmodule

// File: tb/tb_demux_1x8_tdm.sv
// Directed bench for demux_1x8_tdm at DATA_W = 4 with hand-computed frames.
module tb_demux_1x8_tdm;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux_1x8_tdm_if #(.DATA_W(4)) bus ();

  demux_1x8_tdm #(.DATA_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] frame_w;
  logic [2:0]  sel_w;
  assign frame_w = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h};
  assign sel_w   = {bus.sel2, bus.sel1, bus.sel0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic s, input logic [3:0] d);
    bus.din_valid = v;
    bus.sync      = s;
    bus.din       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] w8 [8];
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.din       = 4'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_frame", frame_w, 32'h0);
    chk("rst_sel", {29'h0, sel_w}, 32'h0);
    chk("rst_fdone", {31'h0, bus.frame_done}, 32'h0);
    chk("rst_serr", {31'h0, bus.sync_err}, 32'h0);
    rst_n = 1'b1;

    // Full frame 0,1,0,1,... with sync on the first word
    for (int i = 0; i < 8; i++) begin
      chk("full_sel_pre", {29'h0, sel_w}, i);
      step(1'b1, i == 0, 4'(i % 2));
      chk("full_sel_post", {29'h0, sel_w}, (i + 1) % 8);
      chk("full_fdone", {31'h0, bus.frame_done}, {31'h0, i == 7});
      chk("full_serr", {31'h0, bus.sync_err}, 32'h0);
    end
    chk("full_frame", frame_w, 32'h0101_0101);
    step(1'b0, 1'b0, 4'h0);
    chk("full_fdone_1cyc", {31'h0, bus.frame_done}, 32'h0);

    // Gapped frame: 3 idle cycles between words 4 and 5
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, 4'(i % 2));
      chk("gap_fdone_a", {31'h0, bus.frame_done}, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'hF);
      chk("gap_sel_hold", {29'h0, sel_w}, 32'd4);
      chk("gap_fdone_idle", {31'h0, bus.frame_done}, 32'h0);
    end
    for (int i = 4; i < 8; i++) begin
      step(1'b1, 1'b0, 4'(i % 2));
      chk("gap_fdone_b", {31'h0, bus.frame_done}, {31'h0, i == 7});
    end
    chk("gap_frame", frame_w, 32'h0101_0101);
    chk("gap_serr", {31'h0, bus.sync_err}, 32'h0);

    // Resync after 5 words with 0xA
    step(1'b1, 1'b0, 4'hF);
    step(1'b1, 1'b0, 4'hE);
    step(1'b1, 1'b0, 4'hD);
    step(1'b1, 1'b0, 4'hC);
    step(1'b1, 1'b0, 4'hB);
    chk("resync_sel5", {29'h0, sel_w}, 32'd5);
    step(1'b1, 1'b1, 4'hA);
    chk("resync_serr", {31'h0, bus.sync_err}, 32'h1);
    chk("resync_sel", {29'h0, sel_w}, 32'd1);
    chk("resync_frame_hold", frame_w, 32'h0101_0101);
    chk("resync_fdone0", {31'h0, bus.frame_done}, 32'h0);
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b0, 4'(i));
      if (i == 1) chk("resync_serr_1cyc", {31'h0, bus.sync_err}, 32'h0);
      chk("resync_fdone", {31'h0, bus.frame_done}, {31'h0, i == 7});
    end
    chk("resync_frame", frame_w, 32'hA123_4567);

    // Sync with valid while the counter sits at 7
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'(i));
    chk("s7v_sel7", {29'h0, sel_w}, 32'd7);
    step(1'b1, 1'b1, 4'h9);
    chk("s7v_serr", {31'h0, bus.sync_err}, 32'h1);
    chk("s7v_fdone", {31'h0, bus.frame_done}, 32'h0);
    chk("s7v_sel", {29'h0, sel_w}, 32'd1);
    chk("s7v_frame_hold", frame_w, 32'hA123_4567);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 4'(i));
    chk("s7v_fdone_end", {31'h0, bus.frame_done}, 32'h1);
    chk("s7v_frame", frame_w, 32'h9123_4567);

    // Sync without valid while the counter sits at 7
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'hF);
    step(1'b0, 1'b1, 4'h0);
    chk("s7n_serr", {31'h0, bus.sync_err}, 32'h1);
    chk("s7n_sel", {29'h0, sel_w}, 32'd0);
    chk("s7n_fdone", {31'h0, bus.frame_done}, 32'h0);
    chk("s7n_frame_hold", frame_w, 32'h9123_4567);

    // Sync without valid at counter 0
    step(1'b0, 1'b1, 4'h0);
    chk("s0n_serr", {31'h0, bus.sync_err}, 32'h0);
    chk("s0n_sel", {29'h0, sel_w}, 32'd0);

    // Back-to-back: 16 words 0..15
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, 4'(i));
      chk("b2b_fdone", {31'h0, bus.frame_done}, {31'h0, (i == 7) || (i == 15)});
      if (i == 7)  chk("b2b_frame0", frame_w, 32'h0123_4567);
      if (i == 11) chk("b2b_frame_hold", frame_w, 32'h0123_4567);
      if (i == 15) chk("b2b_frame1", frame_w, 32'h89AB_CDEF);
    end

    // Reset mid-frame is asynchronous and discards the partial frame
    step(1'b1, 1'b0, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h3);
    chk("mid_sel3", {29'h0, sel_w}, 32'd3);
    bus.din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_frame", frame_w, 32'h0);
    chk("mid_rst_sel", {29'h0, sel_w}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w8 = '{4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, w8[i]);
      chk("post_rst_fdone", {31'h0, bus.frame_done}, {31'h0, i == 7});
    end
    chk("post_rst_frame", frame_w, 32'h7654_3210);
    step(1'b0, 1'b0, 4'h0);
    chk("post_rst_fdone_1cyc", {31'h0, bus.frame_done}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
